// File: rtl/mac_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_pipe
// Purpose  : Pipelined multiply-accumulate over framed windows of beats.
//            Product is registered through PIPELINE stages together with the
//            beat controls, then accumulated (optionally saturating) and the
//            window sum is presented one cycle after the closing beat.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accum_pipe #(
    parameter int WIDTHA   = 8,
    parameter int WIDTHB   = 8,
    parameter int WIDTHP   = 32,
    parameter int PIPELINE = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clken,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [WIDTHA-1:0] dataa,
    input  logic [WIDTHB-1:0] datab,
    input  logic [WIDTHP-1:0] bias,
    output logic              out_valid,
    output logic [WIDTHP-1:0] result,
    output logic              overflow,
    output logic              busy
);

    localparam int              c_WPROD = WIDTHA + WIDTHB;
    localparam int              c_WEXT  = WIDTHP + 1;
    localparam int              c_TOP   = PIPELINE - 1;
    localparam logic            c_SX    = (SIGNED != 0);
    localparam logic            c_SAT   = (SATURATE != 0);
    localparam logic [WIDTHP-1:0] c_SMAX = {1'b0, {(WIDTHP-1){1'b1}}};
    localparam logic [WIDTHP-1:0] c_SMIN = {1'b1, {(WIDTHP-1){1'b0}}};
    localparam logic [WIDTHP-1:0] c_UMAX = {WIDTHP{1'b1}};

    // Operands widened to the full product width so a plain multiply yields
    // the exact signed or unsigned product in its low c_WPROD bits.
    logic [c_WPROD-1:0] w_a_ext;
    logic [c_WPROD-1:0] w_b_ext;
    logic [c_WPROD-1:0] w_prod;

    assign w_a_ext = {{WIDTHB{c_SX & dataa[WIDTHA-1]}}, dataa};
    assign w_b_ext = {{WIDTHA{c_SX & datab[WIDTHB-1]}}, datab};
    assign w_prod  = w_a_ext * w_b_ext;

    // Product pipeline with the beat controls and bias riding alongside.
    logic [c_WPROD-1:0]  r_prod [PIPELINE];
    logic [WIDTHP-1:0]   r_bias [PIPELINE];
    logic [PIPELINE-1:0] r_vld;
    logic [PIPELINE-1:0] r_first;
    logic [PIPELINE-1:0] r_last;

    // Shift product, bias and beat flags through PIPELINE register stages.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < PIPELINE; i++) begin
                r_prod[i] <= '0;
                r_bias[i] <= '0;
            end
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
        end else if (clken) begin
            r_prod[0]  <= w_prod;
            r_bias[0]  <= bias;
            r_vld[0]   <= in_valid;
            r_first[0] <= in_first;
            r_last[0]  <= in_last;
            for (int i = 1; i < PIPELINE; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_bias[i]  <= r_bias[i-1];
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    // Accumulator state.
    logic [WIDTHP-1:0] r_acc;
    logic              r_flag;
    logic              r_open;
    logic              r_done;

    logic [WIDTHP-1:0] w_base;
    logic [c_WEXT-1:0] w_base_ext;
    logic [c_WEXT-1:0] w_prod_ext;
    logic [c_WEXT-1:0] w_sum;
    logic              w_ovf;
    logic [WIDTHP-1:0] w_clamp;
    logic [WIDTHP-1:0] w_acc_next;
    logic              w_flag_next;

    // Add the extended product to bias (window start) or the running sum,
    // detect range overflow one bit above WIDTHP and pick the clamp value.
    always_comb begin
        w_base      = r_first[c_TOP] ? r_bias[c_TOP] : r_acc;
        w_base_ext  = {c_SX & w_base[WIDTHP-1], w_base};
        w_prod_ext  = {{(c_WEXT-c_WPROD){c_SX & r_prod[c_TOP][c_WPROD-1]}}, r_prod[c_TOP]};
        w_sum       = w_base_ext + w_prod_ext;
        w_ovf       = c_SX ? (w_sum[WIDTHP] ^ w_sum[WIDTHP-1]) : w_sum[WIDTHP];
        // For signed sums the extra top bit is the true sign: set means the
        // sum went below the minimum. Unsigned sums can only overflow upward.
        w_clamp     = c_SX ? (w_sum[WIDTHP] ? c_SMIN : c_SMAX) : c_UMAX;
        w_acc_next  = (w_ovf && c_SAT) ? w_clamp : w_sum[WIDTHP-1:0];
        w_flag_next = (r_first[c_TOP] ? 1'b0 : r_flag) | w_ovf;
    end

    // Accumulate valid beats and track the open window and its sticky flag.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_acc  <= '0;
            r_flag <= 1'b0;
            r_open <= 1'b0;
            r_done <= 1'b0;
        end else if (clken) begin
            r_done <= 1'b0;
            if (r_vld[c_TOP]) begin
                r_acc  <= w_acc_next;
                r_flag <= w_flag_next;
                r_done <= r_last[c_TOP];
                if (r_last[c_TOP]) begin
                    r_open <= 1'b0;
                end else if (r_first[c_TOP]) begin
                    r_open <= 1'b1;
                end
            end
        end
    end

    // Present the closed window's sum and flag for one enabled cycle.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (clken) begin
            out_valid <= r_done;
            if (r_done) begin
                result   <= r_acc;
                overflow <= r_flag;
            end
        end
    end

    // Busy covers beats in flight, an open window and a pending result.
    assign busy = (|r_vld) | r_open | r_done;

endmodule
`default_nettype wire
